// File: rtl/player_ctrl_grid_pkg.sv
// Shared definitions for the player controller: direction encodings, FSM state
// encodings, sprite indices and two small helper functions.
package player_ctrl_grid_pkg;

    // Direction encoding, shared by player_direction and sword_orientation.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // FSM states.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ATTACK   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    // Sprite indices.
    localparam logic [3:0] SPRITE_IDLE   = 4'd3;
    localparam logic [3:0] SPRITE_WALK   = 4'd2;
    localparam logic [3:0] SPRITE_ATTACK = 4'd4;

    // Button vector {right,left,down,up} to a direction, priority up > down > left > right.
    // With no button pressed the current direction is returned.
    function automatic logic [1:0] pick_dir(input logic [3:0] dirs, input logic [1:0] cur);
        if (dirs[0])      return DIR_UP;
        else if (dirs[1]) return DIR_DOWN;
        else if (dirs[2]) return DIR_LEFT;
        else if (dirs[3]) return DIR_RIGHT;
        else              return cur;
    endfunction

    // Inclusive range test on signed integers so a wrapped (oversized) target
    // coordinate is always reported as out of range.
    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/player_ctrl_grid_anim_ctr.sv
// player_anim_ctr: tick-enabled modulo-ANIM_PERIOD animation counter.
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-low reset (counter -> 0)
//   en         in   advance the counter by one this cycle
//   walk_next  out  1 when the counter value after this cycle is >= ANIM_TOGGLE;
//                   lets the parent register its sprite together with the counter
module player_anim_ctr #(
    parameter int ANIM_PERIOD = 21,
    parameter int ANIM_TOGGLE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic walk_next
);

    localparam int CW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(ANIM_PERIOD - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    assign walk_next = (32'(count_d) >= 32'(ANIM_TOGGLE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/player_ctrl_grid.sv
// player_ctrl_grid: player movement, facing, sword attack and sprite selection on a
// tile grid. All state advances on frame_tick; respawn overrides frame_tick.
// Optional feature macro: PLAYER_COOLDOWN_EN (adds the COOLDOWN state after ATTACK).
// Ports:
//   clk                in   clock
//   reset              in   synchronous, active-low reset
//   frame_tick         in   1-cycle strobe qualifying all state updates
//   respawn            in   1-cycle strobe, returns player to spawn tile
//   btn[4:0]           in   {attack,right,left,down,up}
//   player_x/_y        out  player tile
//   player_direction   out  00 up, 01 right, 10 down, 11 left
//   player_orientation out  last horizontal facing (01 right, 11 left)
//   player_sprite      out  sprite index
//   sword_x/_y         out  sword tile
//   sword_visible      out  sword drawn/active
//   sword_orientation  out  sword direction
//   attack_ready       out  1 while an attack request would be accepted
module player_ctrl_grid
    import player_ctrl_grid_pkg::*;
#(
    parameter int X_W            = 4,
    parameter int Y_W            = 4,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 15,
    parameter int Y_MIN          = 2,
    parameter int Y_MAX          = 11,
    parameter int START_X        = 1,
    parameter int START_Y        = 3,
    parameter int ATTACK_TICKS   = 5,
    parameter int COOLDOWN_TICKS = 3,
    parameter int ANIM_PERIOD    = 21,
    parameter int ANIM_TOGGLE    = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           respawn,
    input  logic [4:0]     btn,
    output logic [X_W-1:0] player_x,
    output logic [Y_W-1:0] player_y,
    output logic [1:0]     player_direction,
    output logic [1:0]     player_orientation,
    output logic [3:0]     player_sprite,
    output logic [X_W-1:0] sword_x,
    output logic [Y_W-1:0] sword_y,
    output logic           sword_visible,
    output logic [1:0]     sword_orientation,
    output logic           attack_ready
);

    localparam int TICK_MAX = (ATTACK_TICKS > COOLDOWN_TICKS) ? ATTACK_TICKS : COOLDOWN_TICKS;
    localparam int TC_W     = $clog2(TICK_MAX + 1);
    localparam logic [TC_W-1:0] AT_LAST = TC_W'(ATTACK_TICKS - 1);
`ifdef PLAYER_COOLDOWN_EN
    localparam logic [TC_W-1:0] CD_LAST = TC_W'(COOLDOWN_TICKS - 1);
`endif
    localparam logic [X_W:0] ONE_X = {{X_W{1'b0}}, 1'b1};
    localparam logic [Y_W:0] ONE_Y = {{Y_W{1'b0}}, 1'b1};

    logic [1:0]      state_q, state_d;
    logic [X_W-1:0]  pos_x_q, pos_x_d;
    logic [Y_W-1:0]  pos_y_q, pos_y_d;
    logic [1:0]      dir_q, dir_d;
    logic [1:0]      ori_q, ori_d;
    logic [3:0]      sprite_q, sprite_d;
    logic [X_W-1:0]  sword_x_q, sword_x_d;
    logic [Y_W-1:0]  sword_y_q, sword_y_d;
    logic            sword_vis_q, sword_vis_d;
    logic [1:0]      sword_ori_q, sword_ori_d;
    logic            ready_q, ready_d;
    logic [TC_W-1:0] tick_q, tick_d, tick_inc;

    logic            any_dir;
    logic [1:0]      new_dir;
    logic [X_W:0]    tgt_x;
    logic [Y_W:0]    tgt_y;
    logic            tgt_ok;
    logic            take_step;
    logic            walk_next;

    assign any_dir  = |btn[3:0];
    assign new_dir  = pick_dir(btn[3:0], dir_q);
    assign tick_inc = (tick_q == {TC_W{1'b1}}) ? tick_q : tick_q + TC_W'(1);

    // Tile one step ahead in new_dir, one bit wider so 0-1 and MAX+1 land out of range.
    always_comb begin
        tgt_x = {1'b0, pos_x_q};
        tgt_y = {1'b0, pos_y_q};
        unique case (new_dir)
            DIR_UP:    tgt_y = {1'b0, pos_y_q} - ONE_Y;
            DIR_DOWN:  tgt_y = {1'b0, pos_y_q} + ONE_Y;
            DIR_LEFT:  tgt_x = {1'b0, pos_x_q} - ONE_X;
            DIR_RIGHT: tgt_x = {1'b0, pos_x_q} + ONE_X;
        endcase
    end

    assign tgt_ok = in_range(int'(tgt_x), X_MIN, X_MAX) && in_range(int'(tgt_y), Y_MIN, Y_MAX);

    player_anim_ctr #(
        .ANIM_PERIOD (ANIM_PERIOD),
        .ANIM_TOGGLE (ANIM_TOGGLE)
    ) u_anim (
        .clk       (clk),
        .reset     (reset),
        .en        (frame_tick & ~respawn),
        .walk_next (walk_next)
    );

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dir_d       = dir_q;
        ori_d       = ori_q;
        sword_x_d   = sword_x_q;
        sword_y_d   = sword_y_q;
        sword_vis_d = sword_vis_q;
        sword_ori_d = sword_ori_q;
        tick_d      = tick_q;
        take_step   = 1'b0;

        if (frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (btn[4]) begin
                        // Facing updates first, the sword is placed in the new direction.
                        dir_d       = new_dir;
                        if (new_dir[0]) ori_d = new_dir;
                        sword_ori_d = new_dir;
                        if (tgt_ok) begin
                            sword_x_d   = tgt_x[X_W-1:0];
                            sword_y_d   = tgt_y[Y_W-1:0];
                            sword_vis_d = 1'b1;
                        end
                        state_d = ST_ATTACK;
                        tick_d  = '0;
                    end else begin
                        take_step = any_dir;
                    end
                end
                ST_ATTACK: begin
                    if (tick_q == AT_LAST) begin
                        sword_vis_d = 1'b0;
                        tick_d      = '0;
`ifdef PLAYER_COOLDOWN_EN
                        state_d     = ST_COOLDOWN;
`else
                        state_d     = ST_IDLE;
`endif
                    end else begin
                        tick_d = tick_inc;
                    end
                end
                ST_COOLDOWN: begin
`ifdef PLAYER_COOLDOWN_EN
                    take_step = any_dir;
                    if (tick_q == CD_LAST) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_inc;
                    end
`else
                    state_d = ST_IDLE;
                    tick_d  = '0;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end
            endcase

            if (take_step) begin
                dir_d = new_dir;
                if (new_dir[0]) ori_d = new_dir;
                if (tgt_ok) begin
                    pos_x_d = tgt_x[X_W-1:0];
                    pos_y_d = tgt_y[Y_W-1:0];
                end
            end
        end

        // Respawn overrides any tick update; direction and animation are kept.
        if (respawn) begin
            pos_x_d     = X_W'(START_X);
            pos_y_d     = Y_W'(START_Y);
            dir_d       = dir_q;
            ori_d       = ori_q;
            sword_x_d   = sword_x_q;
            sword_y_d   = sword_y_q;
            sword_ori_d = sword_ori_q;
            sword_vis_d = 1'b0;
            state_d     = ST_IDLE;
            tick_d      = '0;
        end

        ready_d  = (state_d == ST_IDLE);
        sprite_d = (state_d == ST_ATTACK) ? SPRITE_ATTACK :
                   (walk_next ? SPRITE_WALK : SPRITE_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pos_x_q     <= X_W'(START_X);
            pos_y_q     <= Y_W'(START_Y);
            dir_q       <= DIR_RIGHT;
            ori_q       <= DIR_RIGHT;
            sprite_q    <= SPRITE_IDLE;
            sword_x_q   <= '0;
            sword_y_q   <= '0;
            sword_vis_q <= 1'b0;
            sword_ori_q <= DIR_RIGHT;
            ready_q     <= 1'b1;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_q       <= dir_d;
            ori_q       <= ori_d;
            sprite_q    <= sprite_d;
            sword_x_q   <= sword_x_d;
            sword_y_q   <= sword_y_d;
            sword_vis_q <= sword_vis_d;
            sword_ori_q <= sword_ori_d;
            ready_q     <= ready_d;
            tick_q      <= tick_d;
        end
    end

    assign player_x           = pos_x_q;
    assign player_y           = pos_y_q;
    assign player_direction   = dir_q;
    assign player_orientation = ori_q;
    assign player_sprite      = sprite_q;
    assign sword_x            = sword_x_q;
    assign sword_y            = sword_y_q;
    assign sword_visible      = sword_vis_q;
    assign sword_orientation  = sword_ori_q;
    assign attack_ready       = ready_q;

endmodule

// File: tb/tb_player_ctrl_grid.sv
// Self-checking bench for player_ctrl_grid with default parameters. A behavioural
// model predicts every output after each driven event; the prediction is queued and
// popped for comparison once the DUT has registered the same event.
module tb_player_ctrl_grid;

    localparam int AT = 5;
    localparam int CD = 3;
`ifdef PLAYER_COOLDOWN_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif

    localparam logic [4:0] B_UP    = 5'b00001;
    localparam logic [4:0] B_DOWN  = 5'b00010;
    localparam logic [4:0] B_LEFT  = 5'b00100;
    localparam logic [4:0] B_RIGHT = 5'b01000;
    localparam logic [4:0] B_ATK   = 5'b10000;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] dir;
        logic [1:0] ori;
        logic [3:0] spr;
        logic [3:0] sx;
        logic [3:0] sy;
        logic       sv;
        logic [1:0] so;
        logic       rdy;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       respawn = 1'b0;
    logic [4:0] btn = 5'b0;
    logic [3:0] player_x, player_y, player_sprite, sword_x, sword_y;
    logic [1:0] player_direction, player_orientation, sword_orientation;
    logic       sword_visible, attack_ready;

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];

    // Model state
    int mx, my, mdir, mori, msx, msy, msv, mso, mst, mtc, manim;

    always #5 clk = ~clk;

    player_ctrl_grid dut (
        .clk                (clk),
        .reset              (reset),
        .frame_tick         (frame_tick),
        .respawn            (respawn),
        .btn                (btn),
        .player_x           (player_x),
        .player_y           (player_y),
        .player_direction   (player_direction),
        .player_orientation (player_orientation),
        .player_sprite      (player_sprite),
        .sword_x            (sword_x),
        .sword_y            (sword_y),
        .sword_visible      (sword_visible),
        .sword_orientation  (sword_orientation),
        .attack_ready       (attack_ready)
    );

    function automatic obs_t dut_obs();
        obs_t o;
        o.x = player_x;  o.y = player_y;  o.dir = player_direction;
        o.ori = player_orientation;  o.spr = player_sprite;
        o.sx = sword_x;  o.sy = sword_y;  o.sv = sword_visible;
        o.so = sword_orientation;  o.rdy = attack_ready;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.x = 4'(mx);  o.y = 4'(my);  o.dir = 2'(mdir);  o.ori = 2'(mori);
        o.spr = (mst == 1) ? 4'd4 : ((manim < 8) ? 4'd3 : 4'd2);
        o.sx = 4'(msx);  o.sy = 4'(msy);  o.sv = 1'(msv);  o.so = 2'(mso);
        o.rdy = (mst == 0);
        return o;
    endfunction

    task automatic model_reset();
        mx = 1; my = 3; mdir = 1; mori = 1; msx = 0; msy = 0; msv = 0; mso = 1;
        mst = 0; mtc = 0; manim = 0;
    endtask

    task automatic model_respawn();
        mx = 1; my = 3; msv = 0; mst = 0; mtc = 0;
    endtask

    task automatic model_tick(input logic [4:0] b);
        int nd, dx, dy, tx, ty;
        bit ok, anyd, step;
        anyd = (b[3:0] != 4'b0);
        nd = b[0] ? 0 : b[1] ? 2 : b[2] ? 3 : b[3] ? 1 : mdir;
        dx = (nd == 1) ? 1 : (nd == 3) ? -1 : 0;
        dy = (nd == 2) ? 1 : (nd == 0) ? -1 : 0;
        tx = mx + dx;
        ty = my + dy;
        ok = (tx >= 0) && (tx <= 15) && (ty >= 2) && (ty <= 11);
        step = 0;
        case (mst)
            0: begin
                if (b[4]) begin
                    mdir = nd;
                    if (nd == 1 || nd == 3) mori = nd;
                    mso = nd;
                    if (ok) begin msx = tx; msy = ty; msv = 1; end
                    mst = 1; mtc = 0;
                end else begin
                    step = anyd;
                end
            end
            1: begin
                if (mtc == AT - 1) begin
                    msv = 0; mst = CD_EN ? 2 : 0; mtc = 0;
                end else begin
                    mtc++;
                end
            end
            default: begin
                step = anyd;
                if (mtc == CD - 1) begin mst = 0; mtc = 0; end
                else mtc++;
            end
        endcase
        if (step) begin
            mdir = nd;
            if (nd == 1 || nd == 3) mori = nd;
            if (ok) begin mx = tx; my = ty; end
        end
        manim = (manim == 20) ? 0 : manim + 1;
    endtask

    task automatic do_tick(input logic [4:0] b);
        btn = b;
        frame_tick = 1'b1;
        model_tick(b);
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        btn = 5'b0;
    endtask

    task automatic do_respawn(input logic with_tick, input logic [4:0] b);
        respawn = 1'b1;
        frame_tick = with_tick;
        btn = b;
        model_respawn();
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
        respawn = 1'b0;
        frame_tick = 1'b0;
        btn = 5'b0;
    endtask

    task automatic test_reset();
        obs_t g;
        // Reset must win over respawn and frame_tick.
        reset = 1'b0; frame_tick = 1'b1; respawn = 1'b1; btn = B_UP | B_ATK;
        repeat (2) @(posedge clk);
        #1;
        g = dut_obs();
        checks++; if (g.x !== 4'd1 || g.y !== 4'd3) begin
            errors++; $display("FAIL reset_pos got (%0d,%0d) exp (1,3)", g.x, g.y); end
        checks++; if (g.dir !== 2'b01 || g.ori !== 2'b01) begin
            errors++; $display("FAIL reset_dir got dir %b ori %b exp 01 01", g.dir, g.ori); end
        checks++; if (g.spr !== 4'd3) begin
            errors++; $display("FAIL reset_sprite got %0d exp 3", g.spr); end
        checks++; if (g.sv !== 1'b0 || g.sx !== 4'd0 || g.sy !== 4'd0 || g.so !== 2'b01) begin
            errors++; $display("FAIL reset_sword got v%b (%0d,%0d) o%b exp v0 (0,0) o01",
                               g.sv, g.sx, g.sy, g.so); end
        checks++; if (g.rdy !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", g.rdy); end
        reset = 1'b1; frame_tick = 1'b0; respawn = 1'b0; btn = 5'b0;
        model_reset();
    endtask

    task automatic test_move();
        obs_t e, g;
        logic [4:0] seq [17] = '{B_UP, B_UP, B_DOWN, B_DOWN, B_DOWN, B_UP | B_RIGHT, B_LEFT,
                                 B_LEFT, B_DOWN, B_DOWN, B_DOWN, B_DOWN, B_DOWN, B_DOWN,
                                 B_DOWN, B_DOWN, B_RIGHT};
        for (int i = 0; i < 17; i++) begin
            do_tick(seq[i]);
            e = sb.pop_front();
            g = dut_obs();
            checks++; if (g !== e) begin
                errors++; $display("FAIL move step %0d got %h exp %h", i, g, e); end
            if (i == 1) begin
                checks++; if (g.x !== 4'd1 || g.y !== 4'd2 || g.dir !== 2'b00) begin
                    errors++; $display("FAIL move_top_edge got (%0d,%0d) dir %b exp (1,2) 00",
                                       g.x, g.y, g.dir); end
            end
            if (i == 5) begin
                checks++; if (g.x !== 4'd1 || g.y !== 4'd4 || g.dir !== 2'b00) begin
                    errors++; $display("FAIL move_one_step got (%0d,%0d) dir %b exp (1,4) 00",
                                       g.x, g.y, g.dir); end
            end
            if (i == 7) begin
                checks++; if (g.x !== 4'd0 || g.ori !== 2'b11) begin
                    errors++; $display("FAIL move_left_edge got x %0d ori %b exp 0 11",
                                       g.x, g.ori); end
            end
            if (i == 15) begin
                checks++; if (g.y !== 4'd11) begin
                    errors++; $display("FAIL move_bottom_edge got y %0d exp 11", g.y); end
            end
        end
    endtask

    task automatic test_attack();
        obs_t e, g;
        int vis_cnt, cd_cnt;
        logic [4:0] pre [4] = '{5'b0, B_DOWN, B_DOWN, B_LEFT};
        do_respawn(1'b0, 5'b0);
        e = sb.pop_front(); g = dut_obs();
        checks++; if (g !== e) begin
            errors++; $display("FAIL attack_respawn got %h exp %h", g, e); end
        for (int i = 1; i < 4; i++) begin
            do_tick(pre[i]);
            e = sb.pop_front(); g = dut_obs();
            checks++; if (g !== e) begin
                errors++; $display("FAIL attack_setup %0d got %h exp %h", i, g, e); end
        end
        // At (0,5): attack facing left puts the sword off-grid.
        do_tick(B_ATK | B_LEFT);
        e = sb.pop_front(); g = dut_obs();
        checks++; if (g !== e) begin
            errors++; $display("FAIL attack_offgrid got %h exp %h", g, e); end
        checks++; if (g.dir !== 2'b11 || g.sv !== 1'b0 || g.spr !== 4'd4 || g.rdy !== 1'b0) begin
            errors++; $display("FAIL attack_offgrid_fields got dir %b sv %b spr %0d rdy %b exp 11 0 4 0",
                               g.dir, g.sv, g.spr, g.rdy); end
        for (int i = 0; i < 10; i++) begin
            do_tick(5'b0);
            e = sb.pop_front(); g = dut_obs();
            checks++; if (g !== e) begin
                errors++; $display("FAIL attack_offgrid_tail %0d got %h exp %h", i, g, e); end
        end
        do_respawn(1'b0, 5'b0);
        e = sb.pop_front(); g = dut_obs();
        checks++; if (g !== e) begin
            errors++; $display("FAIL attack_respawn2 got %h exp %h", g, e); end
        do_tick(B_ATK | B_RIGHT);
        e = sb.pop_front(); g = dut_obs();
        checks++; if (g !== e) begin
            errors++; $display("FAIL attack_right got %h exp %h", g, e); end
        checks++; if (g.sx !== 4'd2 || g.sy !== 4'd3 || g.sv !== 1'b1 || g.so !== 2'b01) begin
            errors++; $display("FAIL attack_sword_pos got (%0d,%0d) v%b o%b exp (2,3) v1 o01",
                               g.sx, g.sy, g.sv, g.so); end
        vis_cnt = 1;
        cd_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            do_tick(5'b0);
            e = sb.pop_front(); g = dut_obs();
            checks++; if (g !== e) begin
                errors++; $display("FAIL attack_tail %0d got %h exp %h", i, g, e); end
            if (g.sv === 1'b1) vis_cnt++;
            if (g.rdy === 1'b0 && g.spr !== 4'd4) cd_cnt++;
        end
        checks++; if (vis_cnt != AT) begin
            errors++; $display("FAIL attack_visible_ticks got %0d exp %0d", vis_cnt, AT); end
        checks++; if (cd_cnt != (CD_EN ? CD : 0)) begin
            errors++; $display("FAIL attack_cooldown_ticks got %0d exp %0d", cd_cnt,
                               CD_EN ? CD : 0); end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        logic [4:0] b;
        logic [3:0] prev;
        int retrig;
        do_respawn(1'b0, 5'b0);
        e = sb.pop_front(); g = dut_obs();
        checks++; if (g !== e) begin
            errors++; $display("FAIL hold_respawn got %h exp %h", g, e); end
        prev = g.spr;
        retrig = -1;
        for (int i = 0; i < 16; i++) begin
            b = B_ATK;
            if (CD_EN && i == 6) b = B_ATK | B_DOWN;
            do_tick(b);
            e = sb.pop_front(); g = dut_obs();
            checks++; if (g !== e) begin
                errors++; $display("FAIL hold step %0d got %h exp %h", i, g, e); end
            if (i == 0) begin
                checks++; if (g.spr !== 4'd4) begin
                    errors++; $display("FAIL hold_first_attack got spr %0d exp 4", g.spr); end
            end
            if (CD_EN && i == 6) begin
                checks++; if (g.x !== 4'd1 || g.y !== 4'd4) begin
                    errors++; $display("FAIL hold_cooldown_move got (%0d,%0d) exp (1,4)",
                                       g.x, g.y); end
            end
            if (i > 0 && retrig < 0 && prev !== 4'd4 && g.spr === 4'd4) retrig = i;
            prev = g.spr;
        end
        checks++; if (retrig != (CD_EN ? 9 : 6)) begin
            errors++; $display("FAIL hold_retrigger got tick %0d exp %0d", retrig,
                               CD_EN ? 9 : 6); end
        // Let any attack in flight finish before the next scenario.
        for (int i = 0; i < 10; i++) begin
            do_tick(5'b0);
            e = sb.pop_front(); g = dut_obs();
            checks++; if (g !== e) begin
                errors++; $display("FAIL hold_drain %0d got %h exp %h", i, g, e); end
        end
    endtask

    task automatic test_respawn();
        obs_t e, g;
        do_tick(B_ATK);
        e = sb.pop_front(); g = dut_obs();
        checks++; if (g !== e) begin
            errors++; $display("FAIL respawn_attack got %h exp %h", g, e); end
        do_tick(5'b0);
        e = sb.pop_front(); g = dut_obs();
        checks++; if (g !== e) begin
            errors++; $display("FAIL respawn_attack1 got %h exp %h", g, e); end
        // Respawn together with the next tick: respawn wins.
        do_respawn(1'b1, B_DOWN);
        e = sb.pop_front(); g = dut_obs();
        checks++; if (g !== e) begin
            errors++; $display("FAIL respawn_mid got %h exp %h", g, e); end
        checks++; if (g.x !== 4'd1 || g.y !== 4'd3 || g.sv !== 1'b0 || g.rdy !== 1'b1
                      || g.spr === 4'd4) begin
            errors++; $display("FAIL respawn_mid_fields got (%0d,%0d) sv %b rdy %b spr %0d exp (1,3) 0 1 !4",
                               g.x, g.y, g.sv, g.rdy, g.spr); end
        // No frame_tick: nothing may change whatever the buttons do.
        e = model_obs();
        for (int i = 0; i < 100; i++) begin
            btn = 5'($urandom);
            @(posedge clk);
            #1;
            g = dut_obs();
            checks++; if (g !== e) begin
                errors++; $display("FAIL hold_no_tick clk %0d got %h exp %h", i, g, e); end
        end
        btn = 5'b0;
    endtask

    task automatic test_anim();
        obs_t e, g;
        logic [3:0] exp_spr;
        test_reset();
        for (int i = 1; i <= 30; i++) begin
            do_tick(5'b0);
            e = sb.pop_front(); g = dut_obs();
            exp_spr = ((i % 21) < 8) ? 4'd3 : 4'd2;
            checks++; if (g.spr !== exp_spr || g !== e) begin
                errors++; $display("FAIL anim tick %0d got spr %0d exp %0d (obs %h exp %h)",
                                   i, g.spr, exp_spr, g, e); end
        end
    endtask

    task automatic test_random();
        obs_t e, g;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(15) == 0) do_respawn(1'($urandom), 5'($urandom));
            else do_tick(5'($urandom));
            e = sb.pop_front(); g = dut_obs();
            checks++; if (g !== e) begin
                errors++; $display("FAIL random %0d got %h exp %h", i, g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_attack();
        test_back_to_back();
        test_respawn();
        test_anim();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
